// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the CSR transmit write strobe and the UART
// transmitter. It drains one byte at a time through tx_wr/tx_wdata, paced by
// tx_tbr_valid. After each load pulse, tx_tbr_valid is ignored for HOLD_CYCLES
// cycles so the transmitter has time to raise its busy flag.
// Optional feature: define UART_TX_FIFO_FLUSH_EN to add the synchronous flush port.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_ovrflw,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  tx_tbr_valid,
    output logic                  tx_wr,
    output logic [7:0]            tx_wdata
`ifdef UART_TX_FIFO_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_ZERO   = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] LVL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [3:0]          HOLD_LOAD  = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state_r;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [3:0]            hold_cnt_r;
    logic [DEPTH_LOG2:0]   level_next_s;
    logic                  flush_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  pop_s;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Push/pop qualification and next occupancy. A flush cancels both sides.
    always_comb begin
        push_s       = wr_en && !full && !flush_s;
        drop_s       = wr_en && full;
        pop_s        = (state_r == ST_IDLE) && !empty && !tx_tbr_valid && !flush_s;
        level_next_s = level;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level + LVL_ONE;
            2'b01:   level_next_s = level - LVL_ONE;
            default: level_next_s = level;
        endcase
    end

    // Byte storage. The contents are don't-care until written, so it has no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Sticky overflow: a dropped push wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (clr_ovrflw) begin
            overflow <= 1'b0;
        end
    end

    // Pointers, registered status flags and the drain FSM with its load pulse.
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level      <= LVL_ZERO;
            empty      <= 1'b1;
            full       <= 1'b0;
            state_r    <= ST_IDLE;
            tx_wr      <= 1'b0;
            hold_cnt_r <= 4'd0;
            if (rst) begin
                tx_wdata <= 8'h00;
            end
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            level <= level_next_s;
            empty <= (level_next_s == LVL_ZERO);
            full  <= (level_next_s == LVL_FULL);
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tx_wr    <= 1'b1;
                        tx_wdata <= mem_r[rd_ptr_r];
                        rd_ptr_r <= rd_ptr_r + PTR_ONE;
                        state_r  <= ST_ISSUE;
                    end else begin
                        tx_wr <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    tx_wr      <= 1'b0;
                    hold_cnt_r <= HOLD_LOAD;
                    state_r    <= ST_HOLD;
                end
                ST_HOLD: begin
                    tx_wr <= 1'b0;
                    if (hold_cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 4'd1;
                    end
                end
                default: begin
                    tx_wr   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
